// File: rtl/bf_io_bridge_pkg.sv
// Shared definitions for the brainfuck I/O bridge: drain FSM encodings,
// the default core step divider and the FIFO level-width helper.
package bf_io_bridge_pkg;

    // UART drain sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } drain_state_e;

    // System clocks per core step in the real build.
    localparam int CE_DIV_DEFAULT = 8388608;

    // A level counter must represent 0..depth inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bf_io_bridge_if.sv
// Core-side and UART-side signals of the I/O bridge.
// slave: the bridge itself; master: the core/UART environment.
interface bf_io_bridge_if #(
    parameter int DATA_W = 8
);
    logic              cpu_ce;
    logic              stall;
    logic [DATA_W-1:0] out_data;
    logic              out_en;
    logic              in_req;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_start;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;

    modport slave (
        output cpu_ce, stall, in_data, in_valid, tx_data, tx_start,
        input  out_data, out_en, in_req, tx_ready, rx_data, rx_valid
    );

    modport master (
        input  cpu_ce, stall, in_data, in_valid, tx_data, tx_start,
        output out_data, out_en, in_req, tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/bf_io_bridge_fifo.sv
// bf_byte_fifo: small registered byte FIFO with a combinational head.
// Pointers carry one extra wrap bit so level = wptr - rptr covers 0..DEPTH.
module bf_byte_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       level_o
);
    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [AW:0]                  wptr_q;
    logic [AW:0]                  rptr_q;

    assign level_o = wptr_q - rptr_q;
    assign full_o  = (level_o == (AW+1)'(DEPTH));
    assign empty_o = (wptr_q == rptr_q);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    // Storage and pointers; storage is cleared so an empty head reads as 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q[AW-1:0]] <= wdata_i;
                wptr_q                <= wptr_q + 1'b1;
            end
            if (pop_i) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/bf_io_bridge.sv
// bf_io_bridge: core clock-enable divider, stdout TX FIFO drained to the
// UART transmitter, and stdin RX FIFO fed by the UART receiver.
// Optional terminal echo of received bytes: define BF_IO_ECHO_EN.
module bf_io_bridge
    import bf_io_bridge_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 4,
    parameter int CE_DIV   = CE_DIV_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rstn,
    bf_io_bridge_if.slave              io,
    output logic [lvl_w(TX_DEPTH)-1:0] tx_level,
    output logic                       rx_overflow
`ifdef BF_IO_ECHO_EN
    ,
    output logic                       echo_drop
`endif
);
    localparam int            CW   = $clog2(CE_DIV);
    localparam logic [CW-1:0] TERM = CW'(CE_DIV - 1);

    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       at_term, stall, cpu_ce;
    logic                       core_push;
    logic                       tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_W-1:0]          tx_wdata, tx_head, tx_data_q;
    logic                       rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_W-1:0]          rx_head;
    logic [lvl_w(RX_DEPTH)-1:0] rx_level;
    logic                       rx_overflow_q;
    logic                       tx_start;
    drain_state_e               state_q, state_d;

    // Core step enable: the counter parks at terminal count while stalled.
    assign stall   = (io.out_en && tx_full) || (io.in_req && rx_empty);
    assign at_term = (cnt_q == TERM);
    assign cpu_ce  = at_term && !stall;
    assign cnt_d   = at_term ? (stall ? cnt_q : '0) : cnt_q + 1'b1;

    // Divider count register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Core requests take effect only on the step they were held for.
    assign core_push = cpu_ce && io.out_en;
    assign rx_pop    = cpu_ce && io.in_req;
    // A full RX FIFO still accepts a byte when the core pops in the same cycle.
    assign rx_push   = io.rx_valid && (!rx_full || rx_pop);

`ifdef BF_IO_ECHO_EN
    logic echo_ok, echo_drop_q;
    // The core owns the TX write port when both want it; echo yields.
    assign echo_ok   = rx_push && !core_push && !tx_full;
    assign tx_push   = core_push || echo_ok;
    assign tx_wdata  = core_push ? io.out_data : io.rx_data;
    assign echo_drop = echo_drop_q;

    // Sticky flag for any received byte that could not be echoed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                    echo_drop_q <= 1'b0;
        else if (rx_push && !echo_ok) echo_drop_q <= 1'b1;
    end
`else
    assign tx_push  = core_push;
    assign tx_wdata = io.out_data;
`endif

    // Sticky flag for received bytes lost to a full RX FIFO.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                 rx_overflow_q <= 1'b0;
        else if (io.rx_valid && rx_full && !rx_pop) rx_overflow_q <= 1'b1;
    end

    bf_byte_fifo #(.DATA_W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .wdata_i (tx_wdata),
        .head_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (tx_level)
    );

    bf_byte_fifo #(.DATA_W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .wdata_i (io.rx_data),
        .head_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (rx_level)
    );

    // Drain sequencer state and the byte latched for the transmitter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            tx_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (tx_pop) tx_data_q <= tx_head;
        end
    end

    // Drain sequencer: latch+pop when idle, pulse start, wait for the UART to go busy.
    always_comb begin
        state_d  = state_q;
        tx_pop   = 1'b0;
        tx_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!tx_empty && io.tx_ready) begin
                    tx_pop  = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_start = 1'b1;
                state_d  = ST_BUSY;
            end
            ST_BUSY: begin
                if (!io.tx_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign io.cpu_ce   = cpu_ce;
    assign io.stall    = stall;
    assign io.in_data  = rx_head;
    assign io.in_valid = (rx_level != '0);
    assign io.tx_data  = tx_data_q;
    assign io.tx_start = tx_start;
    assign rx_overflow = rx_overflow_q;
endmodule

// File: tb/tb_bf_io_bridge.sv
// Bench for bf_io_bridge with a short divider and a 2-deep TX FIFO.
module tb_bf_io_bridge;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] tx_level;
    logic       rx_overflow;
`ifdef BF_IO_ECHO_EN
    logic       echo_drop;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] tx_exp, rx_exp;
    int         bfm_busy = 0;
    bit         bfm_hold = 1'b0;

    bf_io_bridge_if #(.DATA_W(8)) io ();

    bf_io_bridge #(.DATA_W(8), .TX_DEPTH(2), .RX_DEPTH(4), .CE_DIV(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .io          (io),
        .tx_level    (tx_level),
        .rx_overflow (rx_overflow)
`ifdef BF_IO_ECHO_EN
        ,
        .echo_drop   (echo_drop)
`endif
    );

    always #5 clk = ~clk;

    // UART transmitter model plus TX scoreboard check on each start pulse.
    always @(negedge clk) begin
        if (!rstn) begin
            bfm_busy = 0;
        end else if (io.tx_start) begin
            n_checks++;
            if (io.tx_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL tx_start_while_busy: tx_ready got %b expected 1", io.tx_ready);
            end
            n_checks++;
            if (tx_q.size() == 0) begin
                n_fail++;
                $display("FAIL tx_unexpected: got %02h expected no byte", io.tx_data);
            end else begin
                tx_exp = tx_q.pop_front();
                if (io.tx_data !== tx_exp) begin
                    n_fail++;
                    $display("FAIL tx_data: got %02h expected %02h", io.tx_data, tx_exp);
                end
            end
            bfm_busy = 3;
        end else if (bfm_busy > 0) begin
            bfm_busy--;
        end
        io.tx_ready = (bfm_busy == 0) && !bfm_hold;
    end

    // RX scoreboard: the core reads in_data on the step that pops.
    always @(negedge clk) begin
        if (rstn && io.cpu_ce && io.in_req) begin
            n_checks++;
            if (rx_q.size() == 0) begin
                n_fail++;
                $display("FAIL rx_unexpected: got %02h expected no pop", io.in_data);
            end else begin
                rx_exp = rx_q.pop_front();
                if (io.in_data !== rx_exp) begin
                    n_fail++;
                    $display("FAIL rx_data: got %02h expected %02h", io.in_data, rx_exp);
                end
            end
        end
    end

    // Hold a core request until its step is granted; caller is just after a posedge.
    task automatic core_step(input logic oe, input logic [7:0] od, input logic ir);
        bit ok = 1'b0;
        io.out_en   = oe;
        io.out_data = od;
        io.in_req   = ir;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (io.cpu_ce) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL core_step_timeout: cpu_ce got 0 expected 1");
        end else if (oe) begin
            tx_q.push_back(od);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_tx_drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_q.size() == 0 && tx_level == 2'd0) break;
        end
        n_checks++;
        if (tx_q.size() != 0 || tx_level !== 2'd0) begin
            n_fail++;
            $display("FAIL tx_drain: pending %0d level %0d expected 0 0", tx_q.size(), tx_level);
        end
    endtask

    task automatic test_reset();
        io.out_en = 0; io.out_data = 0; io.in_req = 0;
        io.rx_valid = 0; io.rx_data = 0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks += 8;
        if (io.cpu_ce !== 1'b0)   begin n_fail++; $display("FAIL rst_cpu_ce: got %b expected 0", io.cpu_ce); end
        if (io.tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start: got %b expected 0", io.tx_start); end
        if (io.tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %02h expected 00", io.tx_data); end
        if (io.in_data !== 8'h00) begin n_fail++; $display("FAIL rst_in_data: got %02h expected 00", io.in_data); end
        if (io.in_valid !== 1'b0) begin n_fail++; $display("FAIL rst_in_valid: got %b expected 0", io.in_valid); end
        if (tx_level !== 2'd0)    begin n_fail++; $display("FAIL rst_tx_level: got %0d expected 0", tx_level); end
        if (rx_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_rx_overflow: got %b expected 0", rx_overflow); end
        if (io.stall !== 1'b0)    begin n_fail++; $display("FAIL rst_stall: got %b expected 0", io.stall); end
    endtask

    task automatic test_divider();
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_checks += 2;
            if (io.cpu_ce !== ((c % 4) == 3)) begin
                n_fail++;
                $display("FAIL div_cpu_ce cycle %0d: got %b expected %b", c, io.cpu_ce, (c % 4) == 3);
            end
            if (io.stall !== 1'b0) begin
                n_fail++;
                $display("FAIL div_stall cycle %0d: got %b expected 0", c, io.stall);
            end
        end
    endtask

    task automatic test_tx_order();
        @(posedge clk); #1;
        core_step(1'b1, 8'h48, 1'b0);
        core_step(1'b1, 8'h69, 1'b0);
        io.out_en = 1'b0;
        wait_tx_drain();
    endtask

    task automatic test_tx_stall();
        int  ce_cnt = 0;
        bit  ok = 1'b0;
        bfm_hold = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        core_step(1'b1, 8'hA1, 1'b0);
        core_step(1'b1, 8'hA2, 1'b0);
        io.out_data = 8'hA3;
        @(negedge clk);
        n_checks += 2;
        if (io.stall !== 1'b1) begin n_fail++; $display("FAIL tx_full_stall: got %b expected 1", io.stall); end
        if (tx_level !== 2'd2) begin n_fail++; $display("FAIL tx_full_level: got %0d expected 2", tx_level); end
        repeat (8) begin
            @(negedge clk);
            if (io.cpu_ce) ce_cnt++;
        end
        n_checks++;
        if (ce_cnt != 0) begin n_fail++; $display("FAIL tx_stall_ce: got %0d pulses expected 0", ce_cnt); end
        @(posedge clk); #1;
        bfm_hold = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!io.stall) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok || io.cpu_ce !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_unstall_ce: released %b cpu_ce got %b expected 1", ok, io.cpu_ce);
        end else begin
            tx_q.push_back(8'hA3);
        end
        @(posedge clk); #1;
        io.out_en = 1'b0;
        wait_tx_drain();
    endtask

    task automatic test_rx_stdin();
        int ce_cnt = 0;
        bit ok = 1'b0;
        @(posedge clk); #1;
        io.in_req = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if (io.stall !== 1'b1)    begin n_fail++; $display("FAIL rx_empty_stall: got %b expected 1", io.stall); end
        if (io.in_valid !== 1'b0) begin n_fail++; $display("FAIL rx_empty_valid: got %b expected 0", io.in_valid); end
        repeat (5) begin
            @(negedge clk);
            if (io.cpu_ce) ce_cnt++;
        end
        n_checks++;
        if (ce_cnt != 0) begin n_fail++; $display("FAIL rx_stall_ce: got %0d pulses expected 0", ce_cnt); end
        @(posedge clk); #1;
        io.rx_valid = 1'b1; io.rx_data = 8'h41;
        rx_q.push_back(8'h41);
`ifdef BF_IO_ECHO_EN
        tx_q.push_back(8'h41);
`endif
        @(posedge clk); #1;
        io.rx_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_checks++;
                if (io.in_valid !== 1'b1) begin n_fail++; $display("FAIL rx_valid_after_push: got %b expected 1", io.in_valid); end
            end
            if (io.cpu_ce) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok || io.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_unstall: ce seen %b stall got %b expected 0", ok, io.stall);
        end
        @(posedge clk); #1;
        io.in_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (io.in_valid !== 1'b0) begin n_fail++; $display("FAIL rx_valid_after_pop: got %b expected 0", io.in_valid); end
        wait_tx_drain();
    endtask

    task automatic test_rx_overflow();
        bfm_hold = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                n_checks++;
                if (rx_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", rx_overflow); end
            end
            io.rx_valid = 1'b1;
            io.rx_data  = 8'h10 + 8'(i);
            if (i < 4) rx_q.push_back(8'h10 + 8'(i));
`ifdef BF_IO_ECHO_EN
            if (i < 2) tx_q.push_back(8'h10 + 8'(i));
`endif
            @(posedge clk); #1;
        end
        io.rx_valid = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (rx_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", rx_overflow); end
        if (io.in_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b expected 1", io.in_valid); end
`ifdef BF_IO_ECHO_EN
        n_checks++;
        if (echo_drop !== 1'b1) begin n_fail++; $display("FAIL ovf_echo_drop: got %b expected 1", echo_drop); end
`endif
        @(posedge clk); #1;
        bfm_hold = 1'b0;
        for (int i = 0; i < 4; i++) core_step(1'b0, 8'h00, 1'b1);
        io.in_req = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (io.in_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: in_valid got %b expected 0", io.in_valid); end
        if (rx_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", rx_overflow); end
        wait_tx_drain();
        @(posedge clk); #1;
        rstn = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (rx_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got %b expected 0", rx_overflow); end
        if (io.tx_start !== 1'b0) begin n_fail++; $display("FAIL rst2_tx_start: got %b expected 0", io.tx_start); end
`ifdef BF_IO_ECHO_EN
        n_checks++;
        if (echo_drop !== 1'b0) begin n_fail++; $display("FAIL echo_drop_cleared: got %b expected 0", echo_drop); end
`endif
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

`ifdef BF_IO_ECHO_EN
    task automatic test_echo();
        @(posedge clk); #1;
        io.rx_valid = 1'b1; io.rx_data = 8'h7A;
        rx_q.push_back(8'h7A);
        tx_q.push_back(8'h7A);
        @(posedge clk); #1;
        io.rx_valid = 1'b0;
        core_step(1'b0, 8'h00, 1'b1);
        io.in_req = 1'b0;
        wait_tx_drain();
        n_checks++;
        if (echo_drop !== 1'b0) begin n_fail++; $display("FAIL echo_clean: got %b expected 0", echo_drop); end
        bfm_hold = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        core_step(1'b1, 8'h55, 1'b0);
        io.out_data = 8'h31;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (io.cpu_ce) begin
                io.rx_valid = 1'b1; io.rx_data = 8'h7B;
                rx_q.push_back(8'h7B);
                tx_q.push_back(8'h31);
                break;
            end
        end
        @(posedge clk); #1;
        io.rx_valid = 1'b0; io.out_en = 1'b0;
        @(negedge clk);
        n_checks += 3;
        if (echo_drop !== 1'b1)   begin n_fail++; $display("FAIL echo_drop_set: got %b expected 1", echo_drop); end
        if (tx_level !== 2'd2)    begin n_fail++; $display("FAIL echo_tx_level: got %0d expected 2", tx_level); end
        if (io.in_valid !== 1'b1) begin n_fail++; $display("FAIL echo_rx_kept: got %b expected 1", io.in_valid); end
        @(posedge clk); #1;
        bfm_hold = 1'b0;
        core_step(1'b0, 8'h00, 1'b1);
        io.in_req = 1'b0;
        wait_tx_drain();
    endtask
`endif

    initial begin
        test_reset();
        test_divider();
        test_tx_order();
        test_tx_stall();
        test_rx_stdin();
        test_rx_overflow();
`ifdef BF_IO_ECHO_EN
        test_echo();
`endif
        n_checks++;
        if (rx_q.size() != 0) begin n_fail++; $display("FAIL rx_leftover: got %0d expected 0", rx_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
